// File: rtl/debug_arb_pkg.sv
// Shared types and constants for the two-host debug-module request arbiter.
package debug_arb_pkg;

  localparam int unsigned DBG_ADDR_W  = 5;
  localparam int unsigned DBG_DATA_W  = 34;
  localparam int unsigned DBG_TIMEOUT = 1024;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;

  localparam logic [1:0] RESP_OK   = 2'd0;
  localparam logic [1:0] RESP_FAIL = 2'd2;
  localparam logic [1:0] RESP_BUSY = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StResp,
    StRet,
    StDrain
  } arb_state_e;

endpackage

// File: rtl/dbg_rr_arb2.sv
// Combinational 2-way round-robin pick: on contention the requester that did not win last goes.
module dbg_rr_arb2
  import debug_arb_pkg::*;
(
  input  logic       i_en,
  input  logic [1:0] i_valid,
  input  logic       i_last,
  output logic [1:0] o_grant,
  output logic       o_winner
);

  always_comb begin
    o_winner = 1'b0;
    o_grant  = 2'b00;
    if (&i_valid) begin
      o_winner = ~i_last;
    end else begin
      o_winner = i_valid[1];
    end
    if (i_en && (|i_valid)) begin
      o_grant = o_winner ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/debug_req_arbiter.sv
// Shares one debug-module request/response port between two hosts, one transaction in flight,
// with a response timeout that returns a fail status and later swallows the stale response.
module debug_req_arbiter
  import debug_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = DBG_ADDR_W,
  parameter int unsigned DATA_W  = DBG_DATA_W,
  parameter int unsigned TIMEOUT = DBG_TIMEOUT
) (
  input  logic              uncoreclk,
  input  logic              uncorerstn,
  input  logic              s0_req_valid,
  output logic              s0_req_ready,
  input  logic [ADDR_W-1:0] s0_req_addr,
  input  logic [1:0]        s0_req_op,
  input  logic [DATA_W-1:0] s0_req_data,
  output logic              s0_resp_valid,
  input  logic              s0_resp_ready,
  output logic [1:0]        s0_resp_resp,
  output logic [DATA_W-1:0] s0_resp_data,
  input  logic              s1_req_valid,
  output logic              s1_req_ready,
  input  logic [ADDR_W-1:0] s1_req_addr,
  input  logic [1:0]        s1_req_op,
  input  logic [DATA_W-1:0] s1_req_data,
  output logic              s1_resp_valid,
  input  logic              s1_resp_ready,
  output logic [1:0]        s1_resp_resp,
  output logic [DATA_W-1:0] s1_resp_data,
  output logic              m_req_valid,
  input  logic              m_req_ready,
  output logic [ADDR_W-1:0] m_req_addr,
  output logic [1:0]        m_req_op,
  output logic [DATA_W-1:0] m_req_data,
  input  logic              m_resp_valid,
  output logic              m_resp_ready,
  input  logic [1:0]        m_resp_resp,
  input  logic [DATA_W-1:0] m_resp_data,
  output logic              busy,
  output logic              owner,
  output logic [7:0]        timeout_cnt
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

  arb_state_e        r_state;
  logic              r_owner;
  logic              r_last;
  logic              r_busy;
  logic              r_m_req_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_op;
  logic [DATA_W-1:0] r_wdata;
  logic              r_m_resp_ready;
  logic              r_s0_resp_valid;
  logic              r_s1_resp_valid;
  logic [1:0]        r_resp;
  logic [DATA_W-1:0] r_rdata;
  logic [TW-1:0]     r_timer;
  logic [7:0]        r_timeout_cnt;

  logic [1:0] w_grant;
  logic       w_winner;
  logic       w_arb_en;
  logic       w_owner_hs;
  logic       w_owner_done;
  logic       w_late_done;

  // Gated by reset so no host sees a grant while the block is held in reset.
  assign w_arb_en = (r_state == StIdle) && uncorerstn;

  dbg_rr_arb2 u_rr_arb (
    .i_en     (w_arb_en),
    .i_valid  ({s1_req_valid, s0_req_valid}),
    .i_last   (r_last),
    .o_grant  (w_grant),
    .o_winner (w_winner)
  );

  assign w_owner_hs   = r_owner ? (r_s1_resp_valid && s1_resp_ready)
                                : (r_s0_resp_valid && s0_resp_ready);
  assign w_owner_done = !(r_s0_resp_valid || r_s1_resp_valid) || w_owner_hs;
  assign w_late_done  = !r_m_resp_ready || m_resp_valid;

  always_ff @(posedge uncoreclk or negedge uncorerstn) begin
    if (!uncorerstn) begin
      r_state         <= StIdle;
      r_owner         <= 1'b0;
      r_last          <= 1'b1;
      r_busy          <= 1'b0;
      r_m_req_valid   <= 1'b0;
      r_addr          <= '0;
      r_op            <= '0;
      r_wdata         <= '0;
      r_m_resp_ready  <= 1'b0;
      r_s0_resp_valid <= 1'b0;
      r_s1_resp_valid <= 1'b0;
      r_resp          <= '0;
      r_rdata         <= '0;
      r_timer         <= '0;
      r_timeout_cnt   <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (|w_grant) begin
            r_owner       <= w_winner;
            r_last        <= w_winner;
            r_addr        <= w_winner ? s1_req_addr : s0_req_addr;
            r_op          <= w_winner ? s1_req_op : s0_req_op;
            r_wdata       <= w_winner ? s1_req_data : s0_req_data;
            r_m_req_valid <= 1'b1;
            r_busy        <= 1'b1;
            r_state       <= StReq;
          end
        end
        StReq: begin
          if (m_req_ready) begin
            r_m_req_valid  <= 1'b0;
            r_m_resp_ready <= 1'b1;
            r_timer        <= '0;
            r_state        <= StResp;
          end
        end
        StResp: begin
          // A real response beats a timeout expiring in the same cycle.
          if (m_resp_valid) begin
            r_resp          <= m_resp_resp;
            r_rdata         <= m_resp_data;
            r_m_resp_ready  <= 1'b0;
            r_s0_resp_valid <= ~r_owner;
            r_s1_resp_valid <= r_owner;
            r_state         <= StRet;
          end else if ((TIMEOUT != 0) && (r_timer == TMAX)) begin
            r_resp          <= RESP_FAIL;
            r_rdata         <= '0;
            r_s0_resp_valid <= ~r_owner;
            r_s1_resp_valid <= r_owner;
            if (r_timeout_cnt != 8'hff) begin
              r_timeout_cnt <= r_timeout_cnt + 8'd1;
            end
            r_state         <= StDrain;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        StRet: begin
          if (w_owner_hs) begin
            r_s0_resp_valid <= 1'b0;
            r_s1_resp_valid <= 1'b0;
            r_busy          <= 1'b0;
            r_state         <= StIdle;
          end
        end
        StDrain: begin
          // Host handshake and stale DM response may complete in either order.
          if (w_owner_hs) begin
            r_s0_resp_valid <= 1'b0;
            r_s1_resp_valid <= 1'b0;
          end
          if (m_resp_valid) begin
            r_m_resp_ready <= 1'b0;
          end
          if (w_owner_done && w_late_done) begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign s0_req_ready  = w_grant[0];
  assign s1_req_ready  = w_grant[1];
  assign m_req_valid   = r_m_req_valid;
  assign m_req_addr    = r_addr;
  assign m_req_op      = r_op;
  assign m_req_data    = r_wdata;
  assign m_resp_ready  = r_m_resp_ready;
  assign s0_resp_valid = r_s0_resp_valid;
  assign s0_resp_resp  = r_resp;
  assign s0_resp_data  = r_rdata;
  assign s1_resp_valid = r_s1_resp_valid;
  assign s1_resp_resp  = r_resp;
  assign s1_resp_data  = r_rdata;
  assign busy          = r_busy;
  assign owner         = r_owner;
  assign timeout_cnt   = r_timeout_cnt;

endmodule

// File: tb/tb_debug_req_arbiter.sv
// Directed, table-driven bench for debug_req_arbiter with a short timeout (8 cycles).
module tb_debug_req_arbiter;

  logic        uncoreclk = 1'b0;
  logic        uncorerstn;
  logic        s0_req_valid, s0_req_ready, s0_resp_valid, s0_resp_ready;
  logic [4:0]  s0_req_addr;
  logic [1:0]  s0_req_op, s0_resp_resp;
  logic [33:0] s0_req_data, s0_resp_data;
  logic        s1_req_valid, s1_req_ready, s1_resp_valid, s1_resp_ready;
  logic [4:0]  s1_req_addr;
  logic [1:0]  s1_req_op, s1_resp_resp;
  logic [33:0] s1_req_data, s1_resp_data;
  logic        m_req_valid, m_req_ready, m_resp_valid, m_resp_ready;
  logic [4:0]  m_req_addr;
  logic [1:0]  m_req_op, m_resp_resp;
  logic [33:0] m_req_data, m_resp_data;
  logic        busy, owner;
  logic [7:0]  timeout_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 uncoreclk = ~uncoreclk;

  debug_req_arbiter #(
    .ADDR_W  (5),
    .DATA_W  (34),
    .TIMEOUT (8)
  ) dut (
    .uncoreclk     (uncoreclk),
    .uncorerstn    (uncorerstn),
    .s0_req_valid  (s0_req_valid),
    .s0_req_ready  (s0_req_ready),
    .s0_req_addr   (s0_req_addr),
    .s0_req_op     (s0_req_op),
    .s0_req_data   (s0_req_data),
    .s0_resp_valid (s0_resp_valid),
    .s0_resp_ready (s0_resp_ready),
    .s0_resp_resp  (s0_resp_resp),
    .s0_resp_data  (s0_resp_data),
    .s1_req_valid  (s1_req_valid),
    .s1_req_ready  (s1_req_ready),
    .s1_req_addr   (s1_req_addr),
    .s1_req_op     (s1_req_op),
    .s1_req_data   (s1_req_data),
    .s1_resp_valid (s1_resp_valid),
    .s1_resp_ready (s1_resp_ready),
    .s1_resp_resp  (s1_resp_resp),
    .s1_resp_data  (s1_resp_data),
    .m_req_valid   (m_req_valid),
    .m_req_ready   (m_req_ready),
    .m_req_addr    (m_req_addr),
    .m_req_op      (m_req_op),
    .m_req_data    (m_req_data),
    .m_resp_valid  (m_resp_valid),
    .m_resp_ready  (m_resp_ready),
    .m_resp_resp   (m_resp_resp),
    .m_resp_data   (m_resp_data),
    .busy          (busy),
    .owner         (owner),
    .timeout_cnt   (timeout_cnt)
  );

  typedef struct {
    int          host;
    logic [4:0]  addr;
    logic [1:0]  op;
    logic [33:0] wdata;
    int          dly;
    logic [1:0]  dm_resp;
    logic [33:0] dm_data;
    logic [1:0]  exp_resp;
    logic [33:0] exp_data;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Starts at a negedge with request valids already driven; returns just after the grant cycle.
  task automatic wait_grant(input string nm, input int exp_host, input int exp_wait);
    int  w;
    bit  got;
    w   = 0;
    got = 1'b0;
    while (w < 40) begin
      #1;
      if (s0_req_ready || s1_req_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge uncoreclk);
      w++;
    end
    check({nm, " grant seen"}, 64'(got), 64'd1);
    check({nm, " s0_req_ready"}, 64'(s0_req_ready), 64'(exp_host == 0));
    check({nm, " s1_req_ready"}, 64'(s1_req_ready), 64'(exp_host == 1));
    if (exp_wait >= 0) check({nm, " grant wait"}, 64'(w), 64'(exp_wait));
  endtask

  task automatic chk_req(input string nm, input logic [4:0] ea, input logic [1:0] eo,
                         input logic [33:0] ed);
    check({nm, " m_req_valid"}, 64'(m_req_valid), 64'd1);
    check({nm, " m_req_addr"}, 64'(m_req_addr), 64'(ea));
    check({nm, " m_req_op"}, 64'(m_req_op), 64'(eo));
    check({nm, " m_req_data"}, 64'(m_req_data), 64'(ed));
    check({nm, " no grant in REQ"}, 64'({s0_req_ready, s1_req_ready}), 64'd0);
  endtask

  // From the grant cycle: checks the registered request, handshakes it after `stall` cycles,
  // then answers after `dly` RESP cycles. Returns on the first cycle the host response is due.
  task automatic dm_serve(input string nm, input logic [4:0] ea, input logic [1:0] eo,
                          input logic [33:0] ed, input int stall, input int dly,
                          input logic [1:0] rr, input logic [33:0] rd, input logic [1:0] drop);
    @(negedge uncoreclk);
    if (drop[0]) s0_req_valid = 1'b0;
    if (drop[1]) s1_req_valid = 1'b0;
    check({nm, " busy"}, 64'(busy), 64'd1);
    repeat (stall) begin
      chk_req(nm, ea, eo, ed);
      @(negedge uncoreclk);
    end
    chk_req(nm, ea, eo, ed);
    m_req_ready = 1'b1;
    @(negedge uncoreclk);
    m_req_ready = 1'b0;
    check({nm, " m_req_valid drop"}, 64'(m_req_valid), 64'd0);
    repeat (dly) @(negedge uncoreclk);
    check({nm, " m_resp_ready"}, 64'(m_resp_ready), 64'd1);
    m_resp_valid = 1'b1;
    m_resp_resp  = rr;
    m_resp_data  = rd;
    @(negedge uncoreclk);
    m_resp_valid = 1'b0;
    m_resp_data  = 34'h3_0F0F_0F0F;
  endtask

  task automatic host_take(input string nm, input int host, input int stall,
                           input logic [1:0] er, input logic [33:0] ed);
    for (int i = 0; i <= stall; i++) begin
      check({nm, " owner resp_valid"}, 64'(host ? s1_resp_valid : s0_resp_valid), 64'd1);
      check({nm, " other resp_valid"}, 64'(host ? s0_resp_valid : s1_resp_valid), 64'd0);
      check({nm, " resp"}, 64'(host ? s1_resp_resp : s0_resp_resp), 64'(er));
      check({nm, " data"}, 64'(host ? s1_resp_data : s0_resp_data), 64'(ed));
      check({nm, " owner"}, 64'(owner), 64'(host));
      check({nm, " no grant in RET"}, 64'({s0_req_ready, s1_req_ready}), 64'd0);
      if (i < stall) @(negedge uncoreclk);
    end
    if (host == 1) s1_resp_ready = 1'b1;
    else s0_resp_ready = 1'b1;
    @(negedge uncoreclk);
    s0_resp_ready = 1'b0;
    s1_resp_ready = 1'b0;
    check({nm, " resp_valid cleared"}, 64'({s0_resp_valid, s1_resp_valid}), 64'd0);
    check({nm, " busy cleared"}, 64'(busy), 64'd0);
  endtask

  task automatic drive_host(input int host, input logic [4:0] a, input logic [1:0] o,
                            input logic [33:0] d);
    if (host == 1) begin
      s1_req_valid = 1'b1; s1_req_addr = a; s1_req_op = o; s1_req_data = d;
    end else begin
      s0_req_valid = 1'b1; s0_req_addr = a; s0_req_op = o; s0_req_data = d;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100us, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    vecs[0] = '{0, 5'h11, 2'd1, 34'h0,           2, 2'd0, 34'h2_DEAD_BEEF,
                2'd0, 34'h2_DEAD_BEEF};
    vecs[1] = '{1, 5'h04, 2'd2, 34'h1_2345_6789, 0, 2'd0, 34'h0,
                2'd0, 34'h0};
    vecs[2] = '{0, 5'h1F, 2'd2, 34'h3_FFFF_FFFF, 5, 2'd3, 34'h0_0000_00AA,
                2'd3, 34'h0_0000_00AA};
    vecs[3] = '{1, 5'h00, 2'd0, 34'h0,           1, 2'd2, 34'h1_0000_0001,
                2'd2, 34'h1_0000_0001};

    uncorerstn = 1'b0;
    {s0_req_valid, s0_resp_ready, s1_req_valid, s1_resp_ready} = '0;
    s0_req_addr = '0; s0_req_op = '0; s0_req_data = '0;
    s1_req_addr = '0; s1_req_op = '0; s1_req_data = '0;
    {m_req_ready, m_resp_valid} = '0;
    m_resp_resp = '0; m_resp_data = '0;

    // Reset state
    repeat (3) @(negedge uncoreclk);
    check("reset m_req_valid", 64'(m_req_valid), 64'd0);
    check("reset m_resp_ready", 64'(m_resp_ready), 64'd0);
    check("reset resp_valids", 64'({s0_resp_valid, s1_resp_valid}), 64'd0);
    check("reset busy/owner", 64'({busy, owner}), 64'd0);
    check("reset timeout_cnt", 64'(timeout_cnt), 64'd0);
    uncorerstn = 1'b1;
    @(negedge uncoreclk);
    check("idle req_ready", 64'({s0_req_ready, s1_req_ready}), 64'd0);

    // Continuous contention: grants alternate starting with host 0, back-to-back
    drive_host(0, 5'h03, 2'd1, 34'h0);
    drive_host(1, 5'h1C, 2'd2, 34'h0_0000_1111);
    for (int i = 0; i < 8; i++) begin
      wait_grant($sformatf("rr%0d", i), i % 2, 0);
      dm_serve($sformatf("rr%0d", i), (i % 2) ? 5'h1C : 5'h03, (i % 2) ? 2'd2 : 2'd1,
               (i % 2) ? 34'h0_0000_1111 : 34'h0, 0, i % 3, 2'd0,
               34'h0_0000_0100 + 34'(i), 2'b00);
      host_take($sformatf("rr%0d", i), i % 2, 0, 2'd0, 34'h0_0000_0100 + 34'(i));
    end
    s0_req_valid = 1'b0;
    s1_req_valid = 1'b0;

    // Single-host vectors
    for (int v = 0; v < 4; v++) begin
      @(negedge uncoreclk);
      drive_host(vecs[v].host, vecs[v].addr, vecs[v].op, vecs[v].wdata);
      wait_grant($sformatf("vec%0d", v), vecs[v].host, 0);
      dm_serve($sformatf("vec%0d", v), vecs[v].addr, vecs[v].op, vecs[v].wdata, 0, vecs[v].dly,
               vecs[v].dm_resp, vecs[v].dm_data, 2'b11);
      host_take($sformatf("vec%0d", v), vecs[v].host, 0, vecs[v].exp_resp, vecs[v].exp_data);
    end

    // Stalls on both sides; host 1 waits throughout and is granted the cycle after
    @(negedge uncoreclk);
    drive_host(0, 5'h0A, 2'd2, 34'h1_5555_AAAA);
    drive_host(1, 5'h16, 2'd1, 34'h0);
    wait_grant("stall", 0, 0);
    dm_serve("stall", 5'h0A, 2'd2, 34'h1_5555_AAAA, 5, 0, 2'd0, 34'h0_1234_5678, 2'b01);
    host_take("stall", 0, 3, 2'd0, 34'h0_1234_5678);
    wait_grant("after stall", 1, 0);
    dm_serve("after stall", 5'h16, 2'd1, 34'h0, 0, 0, 2'd0, 34'h2_0000_0016, 2'b10);
    host_take("after stall", 1, 0, 2'd0, 34'h2_0000_0016);

    // Timeout with silent DM: error at 9 cycles after the request handshake
    @(negedge uncoreclk);
    drive_host(1, 5'h07, 2'd1, 34'h0);
    wait_grant("tmo", 1, 0);
    @(negedge uncoreclk);
    s1_req_valid = 1'b0;
    chk_req("tmo", 5'h07, 2'd1, 34'h0);
    m_req_ready = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge uncoreclk);
      m_req_ready = 1'b0;
      check($sformatf("tmo cyc%0d s1_resp_valid", k), 64'(s1_resp_valid), 64'(k == 9));
    end
    check("tmo resp", 64'(s1_resp_resp), 64'd2);
    check("tmo data", 64'(s1_resp_data), 64'd0);
    check("tmo s0_resp_valid", 64'(s0_resp_valid), 64'd0);
    check("tmo timeout_cnt", 64'(timeout_cnt), 64'd1);
    s1_resp_ready = 1'b1;
    @(negedge uncoreclk);
    s1_resp_ready = 1'b0;
    check("drain resp_valid", 64'(s1_resp_valid), 64'd0);
    check("drain busy", 64'(busy), 64'd1);
    check("drain m_resp_ready", 64'(m_resp_ready), 64'd1);
    m_resp_valid = 1'b1;
    m_resp_resp  = 2'd0;
    m_resp_data  = 34'h0_BAD0_BAD0;
    @(negedge uncoreclk);
    m_resp_valid = 1'b0;
    check("late swallowed busy", 64'(busy), 64'd0);
    check("late swallowed m_resp_ready", 64'(m_resp_ready), 64'd0);
    check("late swallowed resp_valid", 64'({s0_resp_valid, s1_resp_valid}), 64'd0);
    drive_host(1, 5'h08, 2'd1, 34'h0);
    wait_grant("post tmo", 1, 0);
    dm_serve("post tmo", 5'h08, 2'd1, 34'h0, 0, 1, 2'd0, 34'h1_1111_2222, 2'b10);
    host_take("post tmo", 1, 0, 2'd0, 34'h1_1111_2222);

    // Response on the exact expiry cycle wins over the timeout
    @(negedge uncoreclk);
    drive_host(1, 5'h15, 2'd1, 34'h0);
    wait_grant("expiry", 1, 0);
    dm_serve("expiry", 5'h15, 2'd1, 34'h0, 0, 7, 2'd0, 34'h2_0000_0008, 2'b10);
    host_take("expiry", 1, 0, 2'd0, 34'h2_0000_0008);
    check("expiry timeout_cnt", 64'(timeout_cnt), 64'd1);

    // Reset during RESP after host 0 was granted
    @(negedge uncoreclk);
    drive_host(0, 5'h12, 2'd1, 34'h0);
    wait_grant("rst", 0, 0);
    @(negedge uncoreclk);
    s0_req_valid = 1'b0;
    m_req_ready  = 1'b1;
    @(negedge uncoreclk);
    m_req_ready = 1'b0;
    check("rst in RESP", 64'({busy, m_resp_ready}), 64'd3);
    @(negedge uncoreclk);
    uncorerstn = 1'b0;
    #1;
    check("rst m_req", 64'({m_req_valid, m_req_addr, m_req_op}), 64'd0);
    check("rst m_resp_ready", 64'(m_resp_ready), 64'd0);
    check("rst busy/owner", 64'({busy, owner}), 64'd0);
    check("rst resp_valids", 64'({s0_resp_valid, s1_resp_valid}), 64'd0);
    check("rst timeout_cnt", 64'(timeout_cnt), 64'd0);
    @(negedge uncoreclk);
    uncorerstn = 1'b1;
    @(negedge uncoreclk);
    drive_host(0, 5'h01, 2'd1, 34'h0);
    drive_host(1, 5'h02, 2'd1, 34'h0);
    wait_grant("post rst", 0, 0);
    dm_serve("post rst", 5'h01, 2'd1, 34'h0, 0, 0, 2'd0, 34'h0_0000_0077, 2'b11);
    host_take("post rst", 0, 0, 2'd0, 34'h0_0000_0077);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
